// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq -- sequential radix-2 shift-add multiplier
//
// One multiplier bit is consumed per clock (LSB first). A new operation is
// accepted whenever o_ready is high (IDLE or DONE), which allows back-to-back
// multiplies with no idle cycle. The product register o_p is only updated on
// completion and otherwise holds its value.
//
// Build option:
//   MULT_SEQ_SIGNED_EN  defined   -> i_a, i_b, o_p are two's complement
//                       undefined -> i_a, i_b, o_p are unsigned (default)
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_start  begin a multiply (taken only while o_ready is high)
//   i_a      multiplicand, WIDTH bits
//   i_b      multiplier, WIDTH bits
//   o_ready  high when a start will be accepted
//   o_done   one-cycle pulse when o_p holds a new result
//   o_p      product, 2*WIDTH bits
// -----------------------------------------------------------------------------
module mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_ready,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_p
);

    // One guard bit above the product width so no carry is ever dropped.
    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [AW-1:0]      r_mcand, w_mcand_next;
    logic [AW-1:0]      r_acc, w_acc_next;
    logic [AW-1:0]      w_sum;
    logic [WIDTH-1:0]   r_mplier, w_mplier_next;
    logic [CW-1:0]      r_cnt, w_cnt_next;
    logic [2*WIDTH-1:0] r_p, w_p_next;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_last;

`ifdef MULT_SEQ_SIGNED_EN
    logic r_neg, w_neg_next;
    logic w_neg_in;

    // Work on magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit magnitude.
    assign w_mag_a  = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_mag_b  = i_b[WIDTH-1] ? -i_b : i_b;
    assign w_neg_in = i_a[WIDTH-1] ^ i_b[WIDTH-1];
    assign w_result = r_neg ? -w_sum[2*WIDTH-1:0] : w_sum[2*WIDTH-1:0];
`else
    assign w_mag_a  = i_a;
    assign w_mag_b  = i_b;
    assign w_result = w_sum[2*WIDTH-1:0];
`endif

    // Partial sum for the multiplier bit currently at the LSB.
    assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : {AW{1'b0}});
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    assign o_ready = (r_state != S_CALC);
    assign o_done  = (r_state == S_DONE);
    assign o_p     = r_p;

    always_comb begin
        w_state_next  = r_state;
        w_mcand_next  = r_mcand;
        w_acc_next    = r_acc;
        w_mplier_next = r_mplier;
        w_cnt_next    = r_cnt;
        w_p_next      = r_p;
`ifdef MULT_SEQ_SIGNED_EN
        w_neg_next    = r_neg;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_next  = S_CALC;
                    w_mcand_next  = {{(WIDTH+1){1'b0}}, w_mag_a};
                    w_mplier_next = w_mag_b;
                    w_acc_next    = {AW{1'b0}};
                    w_cnt_next    = {CW{1'b0}};
`ifdef MULT_SEQ_SIGNED_EN
                    w_neg_next    = w_neg_in;
`endif
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                // i_start is deliberately not looked at here.
                w_acc_next    = w_sum;
                w_mcand_next  = r_mcand << 1;
                w_mplier_next = r_mplier >> 1;
                w_cnt_next    = r_cnt + 1'b1;
                if (w_last) begin
                    // Final bit: load the finished product straight from the
                    // last partial sum so DONE coincides with the new value.
                    w_state_next = S_DONE;
                    w_p_next     = w_result;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= {AW{1'b0}};
            r_acc    <= {AW{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_p      <= {(2*WIDTH){1'b0}};
`ifdef MULT_SEQ_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_mcand  <= w_mcand_next;
            r_acc    <= w_acc_next;
            r_mplier <= w_mplier_next;
            r_cnt    <= w_cnt_next;
            r_p      <= w_p_next;
`ifdef MULT_SEQ_SIGNED_EN
            r_neg    <= w_neg_next;
`endif
        end
    end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin a multiply; sampled on the rising Clock edge.
REQ-005 A  input  WIDTH  multiplicand.
REQ-006 B  input  WIDTH  multiplier.
REQ-007 Ready  output  1  high when a Start will be accepted.
REQ-008 Done  output  1  one-cycle pulse, high when P holds a new result.
REQ-009 P  output  2*WIDTH  product register.

Function
REQ-010 The block SHALL implement a radix-2 shift-add multiplier with states IDLE, CALC and DONE.
REQ-011 Ready SHALL be high in IDLE and DONE and low in CALC.
REQ-012 Start high while Ready is high at edge k SHALL capture A and B into internal registers, clear the accumulator and enter CALC.
REQ-013 CALC SHALL last exactly WIDTH cycles, processing one multiplier bit per edge, LSB first: add the multiplicand when the bit is 1, then shift.
REQ-014 At edge k+WIDTH the state SHALL become DONE, P SHALL be loaded with the full 2*WIDTH-bit product, and Done SHALL be high for that one cycle.
REQ-015 Latency SHALL be WIDTH+1 edges from the accepting edge to the first cycle with Done high.
REQ-016 From DONE, with Start low, the next edge SHALL enter IDLE; with Start high, it SHALL accept new operands and enter CALC (back-to-back, no idle cycle).
REQ-017 Start while in CALC SHALL be ignored, and A and B SHALL not affect the running operation after capture.
REQ-018 P SHALL hold its value from the DONE cycle until the next DONE cycle or reset.
REQ-019 The product SHALL be exact, with no truncation; the accumulator SHALL be at least 2*WIDTH+1 bits internally so that carries are not lost.
REQ-020 Operands of 0 SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-021 Reset high at an edge SHALL force IDLE, P=0, Done=0, Ready=1 and clear the internal registers, regardless of state.
REQ-022 Reset SHALL take priority over Start on the same edge.
REQ-023 Reset during CALC SHALL abort the operation; no Done pulse SHALL follow.

Configuration
REQ-024 Macro MULT_SEQ_SIGNED_EN SHALL select the operand interpretation.
REQ-025 With MULT_SEQ_SIGNED_EN defined, A, B and P SHALL be two's complement:
- operands are converted to magnitudes at capture;
- the sign is the XOR of the operand MSBs;
- the result is negated when loaded into P.
The latency SHALL be unchanged.
REQ-026 Without MULT_SEQ_SIGNED_EN, A, B and P SHALL be unsigned.
REQ-027 In signed mode, -2^(WIDTH-1) times -2^(WIDTH-1) SHALL yield +2^(2*WIDTH-2) exactly in 2*WIDTH bits.

Verification (WIDTH=4)
REQ-028 Unsigned: Start with A=15, B=15 -> Done high 5 edges later, P=8'hE1; Ready low for 4 cycles.
REQ-029 Back-to-back: Start held high in the DONE cycle with A=3, B=5 -> next Done 5 edges later, P=8'h0F; no IDLE cycle in between.
REQ-030 Busy: Start pulsed with A=0, B=9 during CALC of A=2, B=6 -> P=8'h0C, exactly one Done pulse.
REQ-031 Reset: Reset asserted on the 2nd CALC cycle -> next cycle IDLE, P=0, Ready=1, no Done for the aborted operation.
REQ-032 Signed (macro defined): A=4'b1000, B=4'b0111 -> P=8'hC8 (-56); A=4'b1000, B=4'b1000 -> P=8'h40. Unsigned build with A=4'b1000, B=4'b0111 -> P=8'h38.
REQ-033 Zero: A=0, B=15 -> P=0, Done exactly 5 edges after Start.
